// File: rtl/fetch_unit.sv
// fetch_unit: program counter, ROM addressing and instruction register with stall, redirect and optional rjmp predecode (FETCH_RJMP_PREDECODE_EN)
module fetch_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid
);
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  take_rjmp;
  logic [ADDR_WIDTH-1:0] rjmp_target;
  assign rom_addr = pc;
  assign pc_inc   = pc + ADDR_WIDTH'(1);
`ifdef FETCH_RJMP_PREDECODE_EN
  // 12-bit signed offset, sign-extended then truncated to the PC width
  assign take_rjmp   = rom_data[15:12] == 4'b1100;
  assign rjmp_target = pc_inc + ADDR_WIDTH'($signed(rom_data[11:0]));
`else
  assign take_rjmp   = 1'b0;
  assign rjmp_target = pc_inc;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      pc          <= branch_target;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      instr_pc    <= pc;
      pc          <= take_rjmp ? rjmp_target : pc_inc;
      instr       <= take_rjmp ? '0 : rom_data;
      instr_valid <= !take_rjmp;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed sequence against a falling-edge ROM model with a queue-based scoreboard
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic [15:0] rom [256];
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    logic [15:0] instr;
    logic [7:0]  ipc;
    logic        v;
    logic [7:0]  addr;
  } exp_t;
  exp_t q[$];
  logic [15:0] m_instr = '0;
  logic [7:0]  m_pc = '0;
  logic [7:0]  m_ipc = '0;
  logic        m_v = 1'b0;

  fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;
  always @(negedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic s, input logic b, input logic [7:0] t, input logic r = 1'b0);
    exp_t e;
    stall = s;
    branch_taken = b;
    branch_target = t;
    reset = r;
    if (r) begin
      m_pc = '0; m_instr = '0; m_ipc = '0; m_v = 1'b0;
    end else if (b) begin
      m_pc = t; m_instr = '0; m_v = 1'b0;
    end else if (!s) begin
      m_ipc = m_pc;
`ifdef FETCH_RJMP_PREDECODE_EN
      if (rom[m_pc][15:12] == 4'hC) begin
        m_instr = '0; m_v = 1'b0;
        m_pc = m_pc + 8'd1 + rom[m_pc][7:0];
      end else begin
        m_instr = rom[m_pc]; m_v = 1'b1; m_pc = m_pc + 8'd1;
      end
`else
      m_instr = rom[m_pc]; m_v = 1'b1; m_pc = m_pc + 8'd1;
`endif
    end
    e.instr = m_instr; e.ipc = m_ipc; e.v = m_v; e.addr = m_pc;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("instr", instr, e.instr);
    chk("instr_pc", {8'h0, instr_pc}, {8'h0, e.ipc});
    chk("instr_valid", {15'h0, instr_valid}, {15'h0, e.v});
    chk("rom_addr", {8'h0, rom_addr}, {8'h0, e.addr});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {8'hA5, 8'(i)};
    rom[0] = 16'hE0F0;
    rom[1] = 16'b1011100100110001;
    rom[2] = 16'hE001;
    rom[3] = 16'hB918;
    rom[4] = 16'hB130;
    rom[5] = 16'hB93B;
    rom[6] = 16'b1100111111111101;
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    chk("reset_valid", {15'h0, instr_valid}, 16'h0);
    chk("reset_addr", {8'h0, rom_addr}, 16'h0);
    step(0, 0, 8'h00);
    chk("first_instr", instr, 16'hE0F0);
    step(0, 0, 8'h00);
    chk("out_word", instr, 16'b1011100100110001);
    step(0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'h00);
      chk("stall_ipc", {8'h0, instr_pc}, 16'h0002);
      chk("stall_addr", {8'h0, rom_addr}, 16'h0003);
    end
    step(0, 0, 8'h00);
    chk("release_ipc", {8'h0, instr_pc}, 16'h0003);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
`ifdef FETCH_RJMP_PREDECODE_EN
    chk("rjmp_bubble", {15'h0, instr_valid}, 16'h0);
    step(0, 0, 8'h00);
    chk("rjmp_target", {8'h0, instr_pc}, 16'h0004);
`else
    chk("rjmp_pass", instr, 16'b1100111111111101);
    step(0, 0, 8'h00);
    chk("after_rjmp", {8'h0, instr_pc}, 16'h0007);
`endif
    step(1, 1, 8'h10);
    chk("redir_addr", {8'h0, rom_addr}, 16'h0010);
    step(0, 0, 8'h00);
    chk("redir_ipc", {8'h0, instr_pc}, 16'h0010);
    step(0, 1, 8'hFF);
    step(0, 0, 8'h00);
    chk("wrap_ff", {8'h0, instr_pc}, 16'h00FF);
    step(0, 0, 8'h00);
    chk("wrap_00", {8'h0, instr_pc}, 16'h0000);
    step(0, 1, 8'h20);
    step(1, 1, 8'h30);
    step(0, 0, 8'h00);
    chk("b2b_ipc", {8'h0, instr_pc}, 16'h0030);
    step(1, 0, 8'h00);
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h40, 1);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
